// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module   : core_pkg
// Purpose  : Shared branch condition codes, resolve FSM states and PC step.
// Revision : 1.0
// ============================================================================
package core_pkg;

    localparam logic [2:0]  CMP_EQ  = 3'b000;
    localparam logic [2:0]  CMP_NE  = 3'b001;
    localparam logic [2:0]  CMP_LT  = 3'b010;
    localparam logic [2:0]  CMP_LE  = 3'b011;
    localparam logic [2:0]  CMP_GT  = 3'b100;
    localparam logic [2:0]  CMP_GE  = 3'b101;

    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EVAL  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Codes 110 and 111 have no comparator meaning.
    function automatic logic is_reserved(input logic [2:0] oper);
        return (oper[2:1] == 2'b11);
    endfunction

endpackage
`default_nettype wire

// File: rtl/branch_resolve_unit_flush_counter.sv
`default_nettype none
// ============================================================================
// Module   : flush_counter
// Purpose  : Loadable down-counter with zero flag; holds while hold is high.
// Revision : 1.0
// ============================================================================
module flush_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (!hold) begin
            if (load) begin
                r_count <= load_val;
            end else if (dec && (r_count != '0)) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign count = r_count;
    assign zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Holds branch operands for the external comparator, resolves the
//            verdict, steers the fetch PC and drives redirect/flush.
// Revision : 1.0
// ============================================================================
module branch_resolve_unit
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic        in_is_branch,
    input  logic [2:0]  in_oper,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_offset,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    output logic [2:0]  cmp_oper,
    input  logic        cmp_val,
    output logic [31:0] pc,
    output logic        redirect,
    output logic        flush,
    output logic        br_done,
    output logic        br_taken,
    output logic        err
);

    localparam logic [3:0] C_FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_ret;
    logic [31:0] r_tgt;
    logic        w_branch_hs;
    logic        w_taken;
    logic        w_reserved;
    logic        w_cnt_load;
    logic        w_cnt_dec;
    logic        w_cnt_zero;
    logic [3:0]  w_cnt;

    assign in_ready = (r_state == ST_IDLE) && !stall;

    flush_counter #(
        .WIDTH (4)
    ) u_flush_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (stall),
        .load     (w_cnt_load),
        .load_val (C_FLUSH_LOAD),
        .dec      (w_cnt_dec),
        .count    (w_cnt),
        .zero     (w_cnt_zero)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_branch_hs = in_valid && in_ready && in_is_branch;
        w_reserved  = is_reserved(cmp_oper);
        w_taken     = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_branch_hs) begin
                    w_state_nxt = ST_EVAL;
                end
            end
            ST_EVAL: begin
                w_taken = cmp_val && !w_reserved;
                if (w_taken) begin
                    w_cnt_load  = 1'b1;
                    w_state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_IDLE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (w_cnt_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else if (!stall) begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            cmp_a    <= '0;
            cmp_b    <= '0;
            cmp_oper <= CMP_EQ;
            r_ret    <= '0;
            r_tgt    <= '0;
            redirect <= 1'b0;
            flush    <= 1'b0;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
            err      <= 1'b0;
        end else if (stall) begin
            // Pulses are suppressed; the stalled EVAL re-resolves once released.
            redirect <= 1'b0;
            br_done  <= 1'b0;
            err      <= 1'b0;
        end else begin
            redirect <= 1'b0;
            br_done  <= 1'b0;
            br_taken <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    flush <= 1'b0;
                    if (w_branch_hs) begin
                        cmp_a    <= in_a;
                        cmp_b    <= in_b;
                        cmp_oper <= in_oper;
                        r_ret    <= in_pc + PC_STEP;
                        r_tgt    <= (in_pc + in_offset) & ~32'h3;
                    end else begin
                        pc <= pc + PC_STEP;
                    end
                end
                ST_EVAL: begin
                    br_done  <= 1'b1;
                    br_taken <= w_taken;
                    err      <= w_reserved;
                    if (w_taken) begin
                        pc       <= r_tgt;
                        redirect <= 1'b1;
                        flush    <= 1'b1;
                    end else begin
                        pc <= r_ret;
                    end
                end
                ST_FLUSH: begin
                    if (w_cnt_zero) begin
                        flush <= 1'b0;
                    end
                end
                default: flush <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_resolve_unit
// Purpose  : Directed self-checking bench for branch_resolve_unit.
// Revision : 1.0
// ============================================================================
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_is_branch;
    logic [2:0]  in_oper;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] in_offset;
    logic [31:0] cmp_a;
    logic [31:0] cmp_b;
    logic [2:0]  cmp_oper;
    logic        cmp_val;
    logic [31:0] pc;
    logic        redirect;
    logic        flush;
    logic        br_done;
    logic        br_taken;
    logic        err;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit #(
        .RESET_PC     (32'h0000_0100),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_is_branch (in_is_branch),
        .in_oper      (in_oper),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_offset    (in_offset),
        .cmp_a        (cmp_a),
        .cmp_b        (cmp_b),
        .cmp_oper     (cmp_oper),
        .cmp_val      (cmp_val),
        .pc           (pc),
        .redirect     (redirect),
        .flush        (flush),
        .br_done      (br_done),
        .br_taken     (br_taken),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] vpc;
        logic [2:0]  oper;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] off;
        logic        cval;
        logic [31:0] exp_pc;
        logic        exp_taken;
        logic        exp_err;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("ready_timeout", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic offer_branch(input logic [31:0] vpc, input logic [2:0] oper,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] off);
        in_valid     = 1'b1;
        in_is_branch = 1'b1;
        in_pc        = vpc;
        in_oper      = oper;
        in_a         = a;
        in_b         = b;
        in_offset    = off;
        step();
        in_valid     = 1'b0;
        in_is_branch = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0200, 3'b000, 32'd5, 32'd5, 32'h40,        1'b1, 32'h0000_0240, 1'b1, 1'b0};
        vecs[1] = '{32'h0000_0200, 3'b010, 32'd7, 32'd3, 32'h40,        1'b0, 32'h0000_0204, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0300, 3'b111, 32'd1, 32'd1, 32'h10,        1'b1, 32'h0000_0304, 1'b0, 1'b1};
        vecs[3] = '{32'hFFFF_FFFC, 3'b101, 32'd9, 32'd2, 32'h8,         1'b1, 32'h0000_0004, 1'b1, 1'b0};
        vecs[4] = '{32'h0000_0400, 3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, 1'b1, 32'h0000_03F0, 1'b1, 1'b0};
        vecs[5] = '{32'h0000_0500, 3'b100, 32'd0, 32'd0, 32'h23,        1'b1, 32'h0000_0520, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0600, 3'b110, 32'd0, 32'd0, 32'h4,         1'b0, 32'h0000_0604, 1'b0, 1'b1};

        rst_n = 1'b0; stall = 1'b0; in_valid = 1'b0; in_is_branch = 1'b0;
        in_pc = '0; in_oper = '0; in_a = '0; in_b = '0; in_offset = '0; cmp_val = 1'b0;

        // Reset state and free-running PC
        step();
        chk("rst_pc", pc, 32'h100);
        chk("rst_pulses", {27'd0, redirect, flush, br_done, br_taken, err}, 32'd0);
        chk("rst_cmp_a", cmp_a, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        step(); chk("pc_inc1", pc, 32'h104);
        step(); chk("pc_inc2", pc, 32'h108);
        step(); chk("pc_inc3", pc, 32'h10C);
        chk("idle_pulses", {27'd0, redirect, flush, br_done, br_taken, err}, 32'd0);

        foreach (vecs[i]) begin
            offer_branch(vecs[i].vpc, vecs[i].oper, vecs[i].a, vecs[i].b, vecs[i].off);
            chk($sformatf("v%0d_eval_ready", i), {31'd0, in_ready}, 32'd0);
            chk($sformatf("v%0d_cmp_a", i), cmp_a, vecs[i].a);
            chk($sformatf("v%0d_cmp_b", i), cmp_b, vecs[i].b);
            chk($sformatf("v%0d_cmp_oper", i), {29'd0, cmp_oper}, {29'd0, vecs[i].oper});
            cmp_val = vecs[i].cval;
            step();
            cmp_val = 1'b0;
            chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
            chk($sformatf("v%0d_done", i), {31'd0, br_done}, 32'd1);
            chk($sformatf("v%0d_taken", i), {31'd0, br_taken}, {31'd0, vecs[i].exp_taken});
            chk($sformatf("v%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].exp_taken});
            chk($sformatf("v%0d_flush", i), {31'd0, flush}, {31'd0, vecs[i].exp_taken});
            chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            if (vecs[i].exp_taken) begin
                chk($sformatf("v%0d_fl_ready", i), {31'd0, in_ready}, 32'd0);
                step();
                chk($sformatf("v%0d_fl2", i), {31'd0, flush}, 32'd1);
                chk($sformatf("v%0d_fl2_ready", i), {31'd0, in_ready}, 32'd0);
                chk($sformatf("v%0d_fl2_redir", i), {31'd0, redirect}, 32'd0);
                step();
                chk($sformatf("v%0d_fl_end", i), {31'd0, flush}, 32'd0);
                chk($sformatf("v%0d_fl_pc", i), pc, vecs[i].exp_pc);
            end else begin
                chk($sformatf("v%0d_ready_back", i), {31'd0, in_ready}, 32'd1);
            end
            wait_ready();
        end

        // Stall held through EVAL
        offer_branch(32'h700, 3'b011, 32'd3, 32'd4, 32'h20);
        stall   = 1'b1;
        cmp_val = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall_cmp_a", cmp_a, 32'd3);
            chk("stall_cmp_b", cmp_b, 32'd4);
            chk("stall_cmp_oper", {29'd0, cmp_oper}, 32'd3);
            chk("stall_pulses", {29'd0, redirect, br_done, err}, 32'd0);
        end
        stall = 1'b0;
        step();
        cmp_val = 1'b0;
        chk("stall_res_pc", pc, 32'h720);
        chk("stall_res_redirect", {31'd0, redirect}, 32'd1);
        chk("stall_res_done", {31'd0, br_done}, 32'd1);
        wait_ready();

        // Valid offered under stall must not handshake
        stall = 1'b1;
        in_valid = 1'b1; in_is_branch = 1'b1;
        #1;
        chk("stall_ready", {31'd0, in_ready}, 32'd0);
        step();
        in_valid = 1'b0; in_is_branch = 1'b0;
        stall = 1'b0;
        step();
        chk("stall_no_hs", {31'd0, in_ready}, 32'd1);

        // Async reset during FLUSH of a wrapping branch
        offer_branch(32'hFFFF_FFFC, 3'b000, 32'd1, 32'd1, 32'h8);
        cmp_val = 1'b1;
        step();
        cmp_val = 1'b0;
        chk("wrap_pc", pc, 32'h4);
        chk("wrap_flush", {31'd0, flush}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h100);
        chk("arst_outs", {27'd0, redirect, flush, br_done, br_taken, err}, 32'd0);
        chk("arst_cmp", cmp_a | cmp_b | {29'd0, cmp_oper}, 32'd0);
        chk("arst_ready", {31'd0, in_ready}, 32'd1);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_resume_pc", pc, 32'h104);
        chk("arst_resume_flush", {31'd0, flush}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
